// File: rtl/alu_seq.sv
// alu_seq: 74181-style ALU that evaluates SLICE bits per clock, LSB slice first,
// rippling carry between slices, with valid/ready handshakes on request and result.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cf_in,
  input  logic [3:0]       op,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             cf_out,
  output logic             zf_out,
  output logic             nf_out,
  output logic             vf_out
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST_K = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] logic_fn(input logic [3:0] f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (f)
      4'd0:    r = ~x;
      4'd1:    r = ~(x | y);
      4'd2:    r = ~x & y;
      4'd3:    r = {WIDTH{1'b0}};
      4'd4:    r = ~(x & y);
      4'd5:    r = ~y;
      4'd6:    r = x ^ y;
      4'd7:    r = x & ~y;
      4'd8:    r = ~x | y;
      4'd9:    r = ~(x ^ y);
      4'd10:   r = y;
      4'd11:   r = x & y;
      4'd12:   r = {WIDTH{1'b1}};
      4'd13:   r = x | ~y;
      4'd14:   r = x | y;
      4'd15:   r = x;
      default: r = x;
    endcase
    return r;
  endfunction

  // First addend of the arithmetic function.
  function automatic logic [WIDTH-1:0] arith_x(input logic [3:0] f,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (f)
      4'd0, 4'd4, 4'd6, 4'd8, 4'd9, 4'd12, 4'd15: r = x;
      4'd1, 4'd5, 4'd13:                          r = x | y;
      4'd2, 4'd10, 4'd14:                         r = x | ~y;
      4'd3:                                       r = {WIDTH{1'b0}};
      4'd7:                                       r = x & ~y;
      4'd11:                                      r = x & y;
      default:                                    r = x;
    endcase
    return r;
  endfunction

  // Second addend of the arithmetic function.
  function automatic logic [WIDTH-1:0] arith_y(input logic [3:0] f,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (f)
      4'd0, 4'd1, 4'd2:          r = {WIDTH{1'b0}};
      4'd3, 4'd7, 4'd11, 4'd15:  r = {WIDTH{1'b1}};
      4'd4, 4'd5:                r = x & ~y;
      4'd6:                      r = ~y;
      4'd8, 4'd10:               r = x & y;
      4'd9:                      r = y;
      4'd12, 4'd13, 4'd14:       r = x;
      default:                   r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             cf_q, cf_d;
  logic             zf_q, zf_d;
  logic             nf_q, nf_d;
  logic             vf_q, vf_d;

  logic [WIDTH-1:0] x_s;
  logic [WIDTH-1:0] y_s;
  logic [WIDTH-1:0] lf_s;
  logic [31:0]      base_s;
  logic [SLICE-1:0] xs_s;
  logic [SLICE-1:0] ys_s;
  logic [SLICE-1:0] ls_s;
  logic [SLICE:0]   sum_s;
  logic [SLICE-1:0] slice_s;
  logic [WIDTH-1:0] merged_s;

  // Slice k datapath: carry_q holds cf_in for slice 0 and the previous slice carry after.
  always_comb begin
    x_s      = arith_x(op_q, a_q, b_q);
    y_s      = arith_y(op_q, a_q, b_q);
    lf_s     = logic_fn(op_q, a_q, b_q);
    base_s   = 32'(k_q) * 32'(SLICE);
    xs_s     = SLICE'(x_s >> base_s);
    ys_s     = SLICE'(y_s >> base_s);
    ls_s     = SLICE'(lf_s >> base_s);
    sum_s    = {1'b0, xs_s} + {1'b0, ys_s} + {{SLICE{1'b0}}, carry_q};
    if (mode_q) begin
      slice_s = ls_s;
    end else begin
      slice_s = sum_s[SLICE-1:0];
    end
    merged_s = (res_q & ~(WIDTH'({SLICE{1'b1}}) << base_s))
             | (WIDTH'(slice_s) << base_s);
  end

  // Next-state and next-output logic for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    mode_d      = mode_q;
    carry_d     = carry_q;
    k_d         = k_q;
    res_d       = res_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    cf_d        = cf_q;
    zf_d        = zf_q;
    nf_d        = nf_q;
    vf_d        = vf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          op_d       = op;
          mode_d     = mode;
          carry_d    = cf_in;
          k_d        = {IW{1'b0}};
          res_d      = {WIDTH{1'b0}};
          in_ready_d = 1'b0;
          state_d    = S_BUSY;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_BUSY: begin
        res_d   = merged_s;
        carry_d = sum_s[SLICE];
        if (k_q == LAST_K) begin
          cf_d        = mode_q ? 1'b0 : sum_s[SLICE];
          vf_d        = mode_q ? 1'b0 : ((x_s[WIDTH-1] == y_s[WIDTH-1]) &&
                                         (merged_s[WIDTH-1] != x_s[WIDTH-1]));
          zf_d        = (merged_s == {WIDTH{1'b0}});
          nf_d        = merged_s[WIDTH-1];
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      op_q        <= 4'd0;
      mode_q      <= 1'b0;
      carry_q     <= 1'b0;
      k_q         <= {IW{1'b0}};
      res_q       <= {WIDTH{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cf_q        <= 1'b0;
      zf_q        <= 1'b0;
      nf_q        <= 1'b0;
      vf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      mode_q      <= mode_d;
      carry_q     <= carry_d;
      k_q         <= k_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cf_q        <= cf_d;
      zf_q        <= zf_d;
      nf_q        <= nf_d;
      vf_q        <= vf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign alu_out   = res_q;
  assign cf_out    = cf_q;
  assign zf_out    = zf_q;
  assign nf_out    = nf_q;
  assign vf_out    = vf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors, handshake corner cases and randomized ops on
// 16/8 and 32/8 instances of alu_seq, checked against an arithmetic model.
module tb_alu_seq;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
  } res_t;

  typedef struct packed {
    logic        mode;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cf;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        mode_i = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic        cf_i = 1'b0;

  logic        in_ready16, out_valid16, cf16, zf16, nf16, vf16;
  logic [15:0] res16;
  logic        in_ready32, out_valid32, cf32, zf32, nf32, vf32;
  logic [31:0] res32;

  logic        o_ready, o_valid;
  res_t        o_res;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16), .SLICE(8)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(in_ready16),
    .a(a_i[15:0]), .b(b_i[15:0]), .cf_in(cf_i), .op(op_i), .mode(mode_i),
    .out_valid(out_valid16), .out_ready(out_ready), .alu_out(res16),
    .cf_out(cf16), .zf_out(zf16), .nf_out(nf16), .vf_out(vf16)
  );

  alu_seq #(.WIDTH(32), .SLICE(8)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(in_ready32),
    .a(a_i), .b(b_i), .cf_in(cf_i), .op(op_i), .mode(mode_i),
    .out_valid(out_valid32), .out_ready(out_ready), .alu_out(res32),
    .cf_out(cf32), .zf_out(zf32), .nf_out(nf32), .vf_out(vf32)
  );

  assign o_ready = sel ? in_ready32 : in_ready16;
  assign o_valid = sel ? out_valid32 : out_valid16;
  assign o_res   = sel ? {res32, cf32, zf32, nf32, vf32}
                       : {16'h0000, res16, cf16, zf16, nf16, vf16};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic chk_res(input string nm, input res_t got, input res_t exp);
    chk({nm, ".res"}, got.r, exp.r);
    chk({nm, ".cf"}, 32'(got.c), 32'(exp.c));
    chk({nm, ".zf"}, 32'(got.z), 32'(exp.z));
    chk({nm, ".nf"}, 32'(got.n), 32'(exp.n));
    chk({nm, ".vf"}, 32'(got.v), 32'(exp.v));
  endtask

  // Reference: whole-width sum X+Y+cin in 64-bit arithmetic, logic ops as bitwise formulas.
  function automatic res_t model(input int w, input logic m, input logic [3:0] f,
                                 input logic [31:0] a, input logic [31:0] b, input logic c);
    longint unsigned msk, A, B, X, Y, s, r;
    res_t o;
    msk = (64'd1 << w) - 64'd1;
    A = {32'd0, a} & msk;
    B = {32'd0, b} & msk;
    X = 64'd0;
    Y = 64'd0;
    r = 64'd0;
    o = '0;
    if (m) begin
      case (f)
        4'd0:  r = ~A;
        4'd1:  r = ~(A | B);
        4'd2:  r = ~A & B;
        4'd3:  r = 64'd0;
        4'd4:  r = ~(A & B);
        4'd5:  r = ~B;
        4'd6:  r = A ^ B;
        4'd7:  r = A & ~B;
        4'd8:  r = ~A | B;
        4'd9:  r = ~(A ^ B);
        4'd10: r = B;
        4'd11: r = A & B;
        4'd12: r = msk;
        4'd13: r = A | ~B;
        4'd14: r = A | B;
        default: r = A;
      endcase
      r = r & msk;
    end else begin
      case (f)
        4'd0:  begin X = A;          Y = 64'd0;  end
        4'd1:  begin X = A | B;      Y = 64'd0;  end
        4'd2:  begin X = A | ~B;     Y = 64'd0;  end
        4'd3:  begin X = 64'd0;      Y = msk;    end
        4'd4:  begin X = A;          Y = A & ~B; end
        4'd5:  begin X = A | B;      Y = A & ~B; end
        4'd6:  begin X = A;          Y = ~B;     end
        4'd7:  begin X = A & ~B;     Y = msk;    end
        4'd8:  begin X = A;          Y = A & B;  end
        4'd9:  begin X = A;          Y = B;      end
        4'd10: begin X = A | ~B;     Y = A & B;  end
        4'd11: begin X = A & B;      Y = msk;    end
        4'd12: begin X = A;          Y = A;      end
        4'd13: begin X = A | B;      Y = A;      end
        4'd14: begin X = A | ~B;     Y = A;      end
        default: begin X = A;        Y = msk;    end
      endcase
      X = X & msk;
      Y = Y & msk;
      s = X + Y + {63'd0, c};
      r = s & msk;
      o.c = s[w];
      o.v = (X[w-1] == Y[w-1]) && (r[w-1] != X[w-1]);
    end
    o.r = r[31:0];
    o.z = (r == 64'd0);
    o.n = r[w-1];
    return o;
  endfunction

  // Issue one request, scramble inputs after accept, wait for the result, consume it.
  task automatic run_op(input logic s, input logic m, input logic [3:0] f,
                        input logic [31:0] aa, input logic [31:0] bb, input logic c,
                        output res_t got, output int lat, output bit ok);
    sel = s; mode_i = m; op_i = f; a_i = aa; b_i = bb; cf_i = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_i = $urandom; b_i = $urandom; op_i = 4'($urandom); cf_i = 1'($urandom); mode_i = 1'($urandom);
    lat = 0;
    ok = 1'b0;
    while (lat < 20 && !ok) begin
      @(posedge clk); #1;
      lat++;
      if (o_valid) ok = 1'b1;
    end
    got = o_res;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    res_t got, exp;
    int   lat;
    bit   ok;
    bit   seen;
    int   n;

    vecs[0] = '{1'b0, 4'd9,  32'h00FF, 32'h0001, 1'b0, '{32'h0100, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{1'b0, 4'd6,  32'h0005, 32'h0007, 1'b1, '{32'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[2] = '{1'b0, 4'd6,  32'h0007, 32'h0005, 1'b1, '{32'h0002, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[3] = '{1'b0, 4'd9,  32'hFFFF, 32'h0001, 1'b0, '{32'h0000, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[4] = '{1'b0, 4'd9,  32'h7FFF, 32'h0001, 1'b0, '{32'h8000, 1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[5] = '{1'b1, 4'd6,  32'hF0F0, 32'hFF00, 1'b1, '{32'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[6] = '{1'b1, 4'd3,  32'hF0F0, 32'hFF00, 1'b1, '{32'h0000, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[7] = '{1'b1, 4'd12, 32'h1234, 32'h5678, 1'b1, '{32'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[8] = '{1'b0, 4'd3,  32'h1234, 32'h5678, 1'b1, '{32'h0000, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[9] = '{1'b0, 4'd12, 32'h4000, 32'h0000, 1'b0, '{32'h8000, 1'b0, 1'b0, 1'b1, 1'b1}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready16), 32'd1);
    chk("rst.out_valid", 32'(out_valid16), 32'd0);
    chk_res("rst16", o_res, '0);
    chk("rst32.in_ready", 32'(in_ready32), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready16), 32'd1);
      run_op(1'b0, vecs[i].mode, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cf, got, lat, ok);
      chk($sformatf("vec%0d.timeout", i), 32'(ok), 32'd1);
      chk($sformatf("vec%0d.latency", i), 32'(lat), 32'd2);
      chk_res($sformatf("vec%0d", i), got, vecs[i].exp);
    end

    run_op(1'b1, 1'b0, 4'd9, 32'h0000_00FF, 32'h0000_0001, 1'b0, got, lat, ok);
    chk("w32.timeout", 32'(ok), 32'd1);
    chk("w32.latency", 32'(lat), 32'd4);
    chk_res("w32", got, '{32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0});

    // Backpressure: result held while in_valid stays high with shifting operands.
    sel = 1'b0; mode_i = 1'b0; op_i = 4'd9; a_i = 32'h1234; b_i = 32'h1111; cf_i = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!o_valid && n < 20) begin
      a_i = $urandom;
      @(posedge clk); #1;
      n++;
    end
    chk("bp.wait", 32'(o_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      a_i = $urandom;
      @(posedge clk); #1;
      chk("bp.valid", 32'(o_valid), 32'd1);
      chk("bp.res", o_res.r, 32'h2345);
      chk("bp.in_ready", 32'(o_ready), 32'd0);
    end
    out_ready = 1'b1;
    a_i = 32'h0FFF; b_i = 32'h0001;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.idle_ready", 32'(o_ready), 32'd1);
    chk("bp.idle_valid", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp.accepted", 32'(o_ready), 32'd0);
    n = 0;
    while (!o_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp.next_wait", 32'(o_valid), 32'd1);
    chk("bp.next_res", o_res.r, 32'h1000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Leave nonzero flags, then reset during the first BUSY cycle.
    run_op(1'b0, 1'b0, 4'd9, 32'h7FFF, 32'h0001, 1'b0, got, lat, ok);
    sel = 1'b0; mode_i = 1'b0; op_i = 4'd15; a_i = 32'h8000; b_i = 32'h0; cf_i = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstbusy.valid", 32'(o_valid), 32'd0);
    chk("rstbusy.in_ready", 32'(o_ready), 32'd1);
    chk_res("rstbusy", o_res, '0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (o_valid) seen = 1'b1;
    end
    chk("rstbusy.no_result", 32'(seen), 32'd0);

    for (int i = 0; i < 150; i++) begin
      logic        s, m, c;
      logic [3:0]  f;
      logic [31:0] aa, bb;
      s  = 1'($urandom);
      m  = 1'($urandom);
      f  = 4'($urandom);
      c  = 1'($urandom);
      aa = $urandom;
      bb = $urandom;
      if (i % 8 == 0) aa = 32'hFFFF_FFFF;
      exp = model(s ? 32 : 16, m, f, aa, bb, c);
      run_op(s, m, f, aa, bb, c, got, lat, ok);
      chk($sformatf("rnd%0d.timeout", i), 32'(ok), 32'd1);
      chk($sformatf("rnd%0d.latency", i), 32'(lat), s ? 32'd4 : 32'd2);
      chk_res($sformatf("rnd%0d w%0d m%0d op%0d", i, s ? 32 : 16, m, f), got, exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the 8-bit 74181-style combinational ALU.
- Latches one operation through a valid/ready handshake and evaluates it SLICE bits per clock, LSB slice first, rippling carry between slices.
- Presents a registered result plus carry, zero, negative and overflow flags through a second valid/ready handshake.
- Sits between the register-file read stage and the writeback/flags latch of wide (16/32-bit) datapaths.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE and at least SLICE.
- SLICE, 8, bits evaluated per cycle; NSLICE = WIDTH/SLICE.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cf_in  in  1  carry in; 1 adds +1 in arithmetic mode
- op  in  4  function select
- mode  in  1  1 = logic, 0 = arithmetic
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- alu_out  out  WIDTH  result
- cf_out  out  1  carry out
- zf_out  out  1  result == 0
- nf_out  out  1  result[WIDTH-1]
- vf_out  out  1  signed overflow

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; in_ready=1; out_valid=0; alu_out=0; all flags=0. Reset overrides everything, including an operation in BUSY or a result held in DONE; any such operation is discarded.
- State machine:
  - IDLE: in_ready=1. If in_valid=1, latch a, b, cf_in, op and mode, clear the slice index and the result register, and go to BUSY.
  - BUSY: in_ready=0. Each cycle evaluate slice k (bits k*SLICE .. k*SLICE+SLICE-1) and write it into the result register.
    - Arithmetic: slice k uses carry-in = cf_in for k=0, otherwise the carry out of slice k-1.
    - After slice NSLICE-1, register the flags and go to DONE.
  - DONE: out_valid=1; in_ready=0; outputs held stable. When out_ready=1, go to IDLE with out_valid=0 on the next cycle.
- A new request cannot be accepted in the same cycle a result is consumed; the minimum issue interval is NSLICE+2 cycles.
- Latency: the accept edge plus NSLICE edges; out_valid rises NSLICE cycles after the accept cycle (NSLICE=2 gives out_valid in cycle acc+2).
- Logic mode (mode=1), bitwise result by op:
  - 0 ~A; 1 ~(A|B); 2 ~A&B; 3 all zeros
  - 4 ~(A&B); 5 ~B; 6 A^B; 7 A&~B
  - 8 ~A|B; 9 ~(A^B); 10 B; 11 A&B
  - 12 all ones; 13 A|~B; 14 A|B; 15 A
  - cf_in is ignored; cf_out=0 and vf_out=0.
- Arithmetic mode (mode=0): result = X + Y + cf_in, computed modulo 2^WIDTH. "ones" below means all ones.
  - op 0: X=A, Y=0
  - op 1: X=A|B, Y=0
  - op 2: X=A|~B, Y=0
  - op 3: X=0, Y=ones
  - op 4: X=A, Y=A&~B
  - op 5: X=A|B, Y=A&~B
  - op 6: X=A, Y=~B (A-B with cf_in=1)
  - op 7: X=A&~B, Y=ones
  - op 8: X=A, Y=A&B
  - op 9: X=A, Y=B
  - op 10: X=A|~B, Y=A&B
  - op 11: X=A&B, Y=ones
  - op 12: X=A, Y=A
  - op 13: X=A|B, Y=A
  - op 14: X=A|~B, Y=A
  - op 15: X=A, Y=ones
- Arithmetic flags:
  - cf_out = bit WIDTH of the (WIDTH+1)-bit sum.
  - vf_out = (X[msb]==Y[msb]) && (R[msb]!=X[msb]).
- zf_out and nf_out are computed from the final result in both modes.
- The sliced result must be bit-identical to a single WIDTH-bit evaluation.
- Operands are latched at accept; changes to a, b or op during BUSY or DONE have no effect.
- in_valid asserted while not in IDLE is ignored; it is not queued.

Test Plan:
- WIDTH=16: mode0 op9 a=0x00FF b=0x0001 cf_in=0 -> out_valid 2 cycles after accept; alu_out=0x0100, cf=0, zf=0, nf=0, vf=0.
- mode0 op6 a=0x0005 b=0x0007 cf_in=1 -> 0xFFFE, cf=0, nf=1, vf=0. Repeat with a=0x0007 b=0x0005 -> 0x0002, cf=1.
- mode0 op9 a=0xFFFF b=0x0001 cf_in=0 -> 0x0000, cf=1, zf=1. Then a=0x7FFF b=0x0001 -> 0x8000, vf=1, nf=1, cf=0.
- mode1 op6 a=0xF0F0 b=0xFF00 cf_in=1 -> 0x0FF0, cf=0, vf=0. Then mode1 op3 -> 0x0000, zf=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and changing a -> out_valid and alu_out stable, in_ready=0; out_ready=1 -> next cycle in_ready=1 and the next request is accepted.
- rst=1 in the first BUSY cycle -> next cycle out_valid=0, in_ready=1, alu_out=0, flags=0; no result emitted. Also rerun the first scenario with WIDTH=32, SLICE=8 -> latency 4.
